// File: rtl/wt_cache_param.sv
// Direct-mapped write-through, write-no-allocate cache with a posted-write FIFO.
// Atomic requests bypass the array after draining the FIFO.
module wt_cache_param #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32,
  parameter int INDEX_W    = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_data_w,
  input  logic              cpu_read,
  input  logic              cpu_write,
  input  logic              cpu_atomic,
  output logic              cpu_wait,
  output logic [DATA_W-1:0] cpu_data_r,
  input  logic              inval,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_data_w,
  output logic              ram_read,
  output logic              ram_write,
  output logic              ram_atomic,
  input  logic              ram_wait,
  input  logic [DATA_W-1:0] ram_data_r,
  output logic [2:0]        dbg_state
);

  localparam int TAG_W = ADDR_W - INDEX_W;
  localparam int LINES = 1 << INDEX_W;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] PTR_ONE = 1;

  typedef enum logic [2:0] {IDLE, DRAIN, FILL, ATOM, RESP} state_t;
  state_t state_q, state_d;

  logic [LINES-1:0]  valid_q;
  logic [TAG_W-1:0]  tag_mem  [LINES];
  logic [DATA_W-1:0] data_mem [LINES];
  logic [ADDR_W-1:0] fifo_addr [FIFO_DEPTH];
  logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];
  logic [PTR_W:0]    wr_ptr, rd_ptr;
  logic [DATA_W-1:0] atom_q;

  logic [INDEX_W-1:0] index;
  logic [TAG_W-1:0]   tag;
  logic hit, req, empty, full;
  logic fifo_push, fifo_pop, fill_done, atom_done, atom_inval, wr_hit;

  assign index = cpu_addr[INDEX_W-1:0];
  assign tag   = cpu_addr[ADDR_W-1:INDEX_W];
  assign hit   = valid_q[index] && (tag_mem[index] == tag);
  assign req   = cpu_read || cpu_write;
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                 (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign dbg_state = state_q;

  // Both sides use the same handshake: a strobe is held with stable address and
  // data, and the transfer happens on the rising edge where the wait input is low.
  always_comb begin
    state_d    = state_q;
    cpu_wait   = 1'b0;
    cpu_data_r = '0;
    ram_addr   = '0;
    ram_data_w = '0;
    ram_read   = 1'b0;
    ram_write  = 1'b0;
    ram_atomic = 1'b0;
    fifo_push  = 1'b0;
    fifo_pop   = 1'b0;
    fill_done  = 1'b0;
    atom_done  = 1'b0;
    atom_inval = 1'b0;
    wr_hit     = 1'b0;

    if ((state_q == IDLE || state_q == DRAIN) && !empty) begin
      ram_write  = 1'b1;
      ram_addr   = fifo_addr[rd_ptr[PTR_W-1:0]];
      ram_data_w = fifo_data[rd_ptr[PTR_W-1:0]];
      fifo_pop   = !ram_wait;
    end

    case (state_q)
      IDLE: begin
        if (cpu_write && !cpu_atomic) begin
          // A full FIFO still accepts when its head retires on the same edge.
          cpu_wait  = full && !fifo_pop;
          fifo_push = !cpu_wait;
          wr_hit    = fifo_push && hit;
        end else if (req) begin
          if (!cpu_atomic && hit) begin
            cpu_data_r = data_mem[index];
          end else begin
            cpu_wait = 1'b1;
            state_d  = DRAIN;
          end
        end
      end
      DRAIN: begin
        cpu_wait = req;
        if (!req) begin
          state_d = IDLE;
        end else if (empty) begin
          if (cpu_atomic) begin
            state_d    = ATOM;
            atom_inval = cpu_write && hit;
          end else begin
            state_d = cpu_write ? IDLE : FILL;
          end
        end
      end
      FILL: begin
        cpu_wait = req;
        ram_read = 1'b1;
        ram_addr = cpu_addr;
        if (!ram_wait) begin
          fill_done = 1'b1;
          state_d   = IDLE;
        end
      end
      ATOM: begin
        cpu_wait   = req;
        ram_atomic = 1'b1;
        ram_addr   = cpu_addr;
        if (cpu_write) begin
          ram_write  = 1'b1;
          ram_data_w = cpu_data_w;
        end else begin
          ram_read = 1'b1;
        end
        if (!ram_wait) begin
          atom_done = 1'b1;
          state_d   = RESP;
        end
      end
      RESP: begin
        cpu_data_r = atom_q;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q <= IDLE;
      valid_q <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      atom_q  <= '0;
    end else begin
      state_q <= state_d;
      if (fifo_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (fifo_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      if (atom_done) atom_q <= ram_data_r;
      // Global invalidate wins, so a fill landing on the same edge stays invalid.
      if (inval)           valid_q        <= '0;
      else if (fill_done)  valid_q[index] <= 1'b1;
      else if (atom_inval) valid_q[index] <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (fifo_push) begin
      fifo_addr[wr_ptr[PTR_W-1:0]] <= cpu_addr;
      fifo_data[wr_ptr[PTR_W-1:0]] <= cpu_data_w;
    end
    if (fill_done) begin
      data_mem[index] <= ram_data_r;
      tag_mem[index]  <= tag;
    end else if (wr_hit) begin
      data_mem[index] <= cpu_data_w;
    end
  end

endmodule

// File: tb/tb_wt_cache_param.sv
// Directed bench for wt_cache_param: RAM model, write-order scoreboard and
// latency/data checks on the CPU side.
module tb_wt_cache_param;

  logic        clk;
  logic        clr_n;
  logic [31:0] cpu_addr, cpu_data_w, cpu_data_r;
  logic        cpu_read, cpu_write, cpu_atomic, cpu_wait, inval;
  logic [31:0] ram_addr, ram_data_w, ram_data_r;
  logic        ram_read, ram_write, ram_atomic, ram_wait;
  logic [2:0]  dbg_state;

  wt_cache_param dut (
    .clk(clk), .clr_n(clr_n),
    .cpu_addr(cpu_addr), .cpu_data_w(cpu_data_w),
    .cpu_read(cpu_read), .cpu_write(cpu_write), .cpu_atomic(cpu_atomic),
    .cpu_wait(cpu_wait), .cpu_data_r(cpu_data_r), .inval(inval),
    .ram_addr(ram_addr), .ram_data_w(ram_data_w),
    .ram_read(ram_read), .ram_write(ram_write), .ram_atomic(ram_atomic),
    .ram_wait(ram_wait), .ram_data_r(ram_data_r), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  logic [63:0] exp_q[$];
  logic [31:0] ram_mem [256];
  logic [31:0] last_rd_addr, last_atom_addr, last_atom_data;
  logic        last_atom_wr;

  assign ram_data_r = ram_mem[ram_addr[7:0]];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // RAM model and scoreboard: inputs change only just after posedge, so the
  // value seen at negedge is the one the next posedge will act on.
  always @(negedge clk) begin
    if (clr_n) begin
      if (ram_read && !ram_atomic) check("rd_after_drain", exp_q.size(), 0);
      if (ram_atomic) check("atom_after_drain", exp_q.size(), 0);
      if (ram_write && !ram_atomic && !ram_wait) begin
        if (exp_q.size() == 0) begin
          check("unexpected_ram_write", {ram_addr, ram_data_w}, 64'd0);
        end else begin
          logic [63:0] e;
          e = exp_q.pop_front();
          check("ram_wr_order", {ram_addr, ram_data_w}, e);
        end
        ram_mem[ram_addr[7:0]] = ram_data_w;
      end
      if (ram_read && !ram_atomic && !ram_wait) last_rd_addr = ram_addr;
      if (ram_atomic && !ram_wait) begin
        last_atom_wr   = ram_write;
        last_atom_addr = ram_addr;
        last_atom_data = ram_data_w;
        if (ram_write) ram_mem[ram_addr[7:0]] = ram_data_w;
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_req(input logic wr, input logic atom, input logic [31:0] addr,
                         input logic [31:0] data, output logic [31:0] rdata,
                         output int waits);
    bit done;
    done       = 1'b0;
    waits      = 0;
    rdata      = '0;
    cpu_addr   = addr;
    cpu_data_w = data;
    cpu_write  = wr;
    cpu_read   = !wr;
    cpu_atomic = atom;
    if (wr && !atom) exp_q.push_back({addr, data});
    for (int c = 0; c < 200 && !done; c++) begin
      #1;
      if (!cpu_wait) begin
        rdata = cpu_data_r;
        done  = 1'b1;
      end else begin
        waits++;
      end
      tick();
    end
    if (!done) begin
      n_assert++;
      n_fail++;
      $error("FAIL req_timeout addr=%0d observed=still waiting expected=done", addr);
    end
    cpu_write  = 1'b0;
    cpu_read   = 1'b0;
    cpu_atomic = 1'b0;
  endtask

  task automatic wait_drain();
    int c;
    c = 0;
    while ((exp_q.size() != 0 || ram_write) && c < 100) begin
      tick();
      c++;
    end
    check("drain_done", exp_q.size(), 0);
  endtask

  logic [31:0] rd, d0;
  int w;

  initial begin
    for (int i = 0; i < 256; i++) ram_mem[i] = 32'h1000 + i;
    clr_n = 1'b0; cpu_addr = '0; cpu_data_w = '0; cpu_read = 1'b0;
    cpu_write = 1'b0; cpu_atomic = 1'b0; inval = 1'b0; ram_wait = 1'b0;
    tick(); tick();
    check("rst_cpu_wait", cpu_wait, 0);
    check("rst_ram_strobes", {ram_read, ram_write, ram_atomic}, 0);
    check("rst_ram_addr", ram_addr, 0);
    check("rst_ram_data_w", ram_data_w, 0);
    check("rst_cpu_data_r", cpu_data_r, 0);
    check("rst_state", dbg_state, 0);
    clr_n = 1'b1;
    tick();

    // posted write, held on RAM port while ram_wait is high
    ram_wait = 1'b1;
    cpu_req(1, 0, 32'd39, 32'd1115, rd, w);
    check("wr_waits", w, 0);
    check("wr_held_strobe", ram_write, 1);
    check("wr_held_addr", ram_addr, 39);
    check("wr_held_data", ram_data_w, 1115);
    ram_wait = 1'b0;
    tick();
    check("wr_fifo_empty", ram_write, 0);
    cpu_req(0, 0, 32'd39, '0, rd, w);
    check("miss_waits", w, 3);
    check("miss_data", rd, 1115);
    check("miss_ram_addr", last_rd_addr, 39);
    cpu_req(0, 0, 32'd39, '0, rd, w);
    check("hit_waits", w, 0);
    check("hit_data", rd, 1115);

    // fill the FIFO, fifth write stalls until the head retires
    ram_wait = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cpu_req(1, 0, 32'd80 + i, $urandom_range(1, 60000), rd, w);
      check("fifo_fill_waits", w, 0);
    end
    cpu_addr = 32'd84; cpu_data_w = $urandom_range(1, 60000); cpu_write = 1'b1;
    exp_q.push_back({cpu_addr, cpu_data_w});
    #1;
    check("full_wait0", cpu_wait, 1);
    tick();
    check("full_wait1", cpu_wait, 1);
    ram_wait = 1'b0;
    #1;
    check("full_accept_on_pop", cpu_wait, 0);
    tick();
    cpu_write = 1'b0;
    wait_drain();

    // write hit updates the line while the write is still posted
    cpu_req(0, 0, 32'd67, '0, rd, w);
    check("fill67_data", rd, 32'h1043);
    ram_wait = 1'b1;
    cpu_req(1, 0, 32'd67, 32'd7777, rd, w);
    check("wr_hit_waits", w, 0);
    cpu_req(0, 0, 32'd67, '0, rd, w);
    check("wr_hit_read_waits", w, 0);
    check("wr_hit_read_data", rd, 7777);
    check("wr_hit_still_pending", ram_write, 1);
    ram_wait = 1'b0;
    wait_drain();

    // read miss behind two queued writes
    ram_wait = 1'b1;
    cpu_req(1, 0, 32'd90, 32'd11, rd, w);
    cpu_req(1, 0, 32'd91, 32'd22, rd, w);
    fork begin repeat (3) tick(); ram_wait = 1'b0; end join_none
    cpu_req(0, 0, 32'd70, '0, rd, w);
    check("miss_behind_fifo_waits", w >= 5, 1);
    check("miss_behind_fifo_data", rd, 32'h1046);

    // atomic write to a cached line drains FIFO and invalidates the line
    cpu_req(0, 0, 32'd71, '0, rd, w);
    check("fill71_waits", w, 3);
    ram_wait = 1'b1;
    d0 = $urandom_range(100, 999);
    cpu_req(1, 0, 32'd95, d0, rd, w);
    fork begin repeat (2) tick(); ram_wait = 1'b0; end join_none
    cpu_req(1, 1, 32'd71, 32'd5, rd, w);
    check("atom_wr_is_write", last_atom_wr, 1);
    check("atom_wr_addr", last_atom_addr, 71);
    check("atom_wr_data", last_atom_data, 5);
    cpu_req(0, 0, 32'd71, '0, rd, w);
    check("after_atom_miss_waits", w, 3);
    check("after_atom_data", rd, 5);
    cpu_req(0, 1, 32'd67, '0, rd, w);
    check("atom_rd_waits", w, 3);
    check("atom_rd_data", rd, 7777);
    check("atom_rd_is_read", last_atom_wr, 0);
    cpu_req(0, 0, 32'd67, '0, rd, w);
    check("atom_rd_no_evict", w, 0);

    // global invalidate
    cpu_req(0, 0, 32'd40, '0, rd, w);
    check("fill40_data", rd, 32'h1028);
    cpu_req(0, 0, 32'd41, '0, rd, w);
    cpu_req(0, 0, 32'd40, '0, rd, w);
    check("pre_inval_hit", w, 0);
    inval = 1'b1;
    tick();
    inval = 1'b0;
    cpu_req(0, 0, 32'd40, '0, rd, w);
    check("inval40_waits", w, 3);
    cpu_req(0, 0, 32'd41, '0, rd, w);
    check("inval41_waits", w, 3);
    check("inval41_data", rd, 32'h1029);

    // reset during FILL
    ram_wait = 1'b1;
    cpu_addr = 32'd50; cpu_read = 1'b1;
    tick(); tick();
    check("fill_state", dbg_state, 2);
    check("fill_ram_read", ram_read, 1);
    clr_n = 1'b0; cpu_read = 1'b0;
    #1;
    check("abort_ram_read", ram_read, 0);
    check("abort_cpu_wait", cpu_wait, 0);
    check("abort_ram_addr", ram_addr, 0);
    check("abort_state", dbg_state, 0);
    tick();
    clr_n = 1'b1; ram_wait = 1'b0;
    tick();
    cpu_req(0, 0, 32'd40, '0, rd, w);
    check("post_rst_miss", w, 3);
    check("sb_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/wt_cache_param.md
# wt_cache_param

Parametrised write-through, write-no-allocate, direct-mapped cache with a posted-write FIFO of configurable depth, sitting between one core's load/store port and the shared RAM port. Successor to the fixed-size cache: line count, data/address width and write-buffer depth are parameters. It adds a global invalidate input and atomic bypass that drains the write buffer and invalidates the matching line.

## Interface
- DATA_W, 32, data width (one word per line)
- ADDR_W, 32, word address width
- INDEX_W, 4, log2 of line count (16 lines); tag = cpu_addr[ADDR_W-1:INDEX_W]
- FIFO_DEPTH, 4, posted-write entries, power of two, ≥2
- clk  in  1  clock, rising edge
- clr_n  in  1  asynchronous, active-low reset
- cpu_addr  in  ADDR_W  word address
- cpu_data_w  in  DATA_W  store data
- cpu_read / cpu_write  in  1  request strobes, held until cpu_wait low
- cpu_atomic  in  1  qualifies current request as atomic (uncached)
- cpu_wait  out  1  request not yet complete
- cpu_data_r  out  DATA_W  load data, valid when cpu_read=1 and cpu_wait=0
- inval  in  1  invalidate all lines
- ram_addr / ram_data_w  out  ADDR_W / DATA_W  RAM request
- ram_read / ram_write / ram_atomic  out  1  RAM strobes
- ram_wait  in  1  RAM busy
- ram_data_r  in  DATA_W  RAM read data

## Operation
- CPU handshake: request completes on the rising edge where the strobe is high and cpu_wait=0. cpu_wait is 0 when no request is present.
- RAM handshake: the cache holds strobe, addr and data stable. Transfer completes on the edge where the strobe is high and ram_wait=0; ram_data_r is sampled at that edge. At most one RAM strobe is high at a time.
- Both cpu_read and cpu_write high: illegal. The write is processed and the read is ignored.
- FSM states: IDLE, DRAIN, FILL, ATOM, RESP.
- Cached read hit (IDLE, valid and tag match): cpu_wait=0 combinationally; cpu_data_r = line data.
- Cached read miss: IDLE→DRAIN.
  - DRAIN waits until the FIFO is empty, then →FILL.
  - FILL drives ram_read. On completion the line is written with data, tag and valid=1, then →IDLE, where the request hits.
- Cached write: accepted in IDLE if the FIFO is not full (cpu_wait=0). The entry is pushed. On a tag hit the line data is updated the same edge; a miss leaves the array untouched. FIFO full: cpu_wait=1, no update.
- FIFO drain: when not empty and the state is IDLE or DRAIN, the head drives ram_write (ram_atomic=0) and pops on completion. Entries retire in order.
- Atomic (cpu_atomic with read or write): IDLE→DRAIN→ATOM.
  - ATOM drives the strobe with ram_atomic=1.
  - Write: invalidates the matching line on entry to ATOM.
  - Read: captures ram_data_r; no allocation.
  - On completion →RESP. RESP holds cpu_wait=0 for one cycle with the captured data, then →IDLE.
- inval: clears all valid bits at the next edge. A FILL completing on the same edge is written but left invalid. The FIFO is unaffected.
- Reset: FSM IDLE, all valid bits 0, FIFO empty. ram_read, ram_write and ram_atomic are 0; ram_addr, ram_data_w and cpu_data_r are 0; cpu_wait=0.
- Reset mid-transaction aborts immediately. RAM strobes drop asynchronously and the pending FIFO contents are discarded.

## Timing
- Read hit: 0 wait cycles.
- Read miss, FIFO empty, ram_wait=0:
  - edge 0: detect miss (→DRAIN)
  - edge 1: DRAIN→FILL
  - edge 2: fill completes
  - cycle 3: hit, cpu_wait=0, so 3 wait cycles
  - Each ram_wait cycle adds one wait cycle; each FIFO entry adds at least one.
- Write, FIFO not full: 0 wait cycles. The head reaches ram_write the cycle after the push at the earliest.
- Atomic with empty FIFO and ram_wait=0: completion in RESP, 3 wait cycles.
- FIFO full/empty from a wrap-bit pointer compare. A push and pop on the same edge while full is allowed; the count is unchanged.

## Test plan
- Reset, then write 1115 to addr 39 with ram_wait=1 for 1 cycle → cpu_wait=0; ram_write addr 39 / data 1115 held until ram_wait falls, then FIFO empty. Read addr 39 → miss, ram_read addr 39, returns 1115; second read hits with 0 waits.
- Fill FIFO with 4 writes (ram_wait=1) → 5th write sees cpu_wait=1 until the first ram_write completes. Writes retire to RAM in issue order.
- Write 7777 to addr 67 while the same line is cached → array updated. Read addr 67 hits 7777 with 0 waits while ram_write is still pending.
- Read miss on addr 70 with 2 queued writes → ram_read asserted only after both ram_write complete.
- Atomic write 5 to cached addr 71 → FIFO drained, ram_atomic=1 with ram_write. The next read of 71 misses.
- Assert inval after caching addrs 40 and 41 → both re-read with misses. Assert clr_n=0 during FILL → ram_read drops immediately, all outputs at reset values.
